// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline control definitions: per-stage stall masks, the ERET
// exception code, the default exception entry address and controller states.
// Imported by every pipeline stage that needs the stall or exception encodings.
package pipe_ctrl_pkg;

  // stall bit order: 0 PC, 1 IF/ID-in, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
  localparam logic [5:0] STALL_MASK_IF  = 6'b000011;
  localparam logic [5:0] STALL_MASK_ID  = 6'b000111;
  localparam logic [5:0] STALL_MASK_EX  = 6'b001111;
  localparam logic [5:0] STALL_MASK_MEM = 6'b011111;

  localparam logic [31:0] EXC_NONE        = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET        = 32'h0000_000e;
  localparam logic [31:0] EXC_VECTOR_DEF  = 32'h0000_0020;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } ctrl_state_t;

  // Masks nest, so OR-ing them leaves the deepest requesting stage in charge.
  function automatic logic [5:0] stall_mask(input logic req_if, input logic req_id,
                                            input logic req_ex, input logic req_mem);
    logic [5:0] m;
    m = 6'b0;
    if (req_if)  m = m | STALL_MASK_IF;
    if (req_id)  m = m | STALL_MASK_ID;
    if (req_ex)  m = m | STALL_MASK_EX;
    if (req_mem) m = m | STALL_MASK_MEM;
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// stall_watchdog: counts consecutive stalled cycles (8-bit, saturating) and
// raises a sticky timeout flag on the edge the count reaches STALL_LIMIT.
// Ports: clk, rst (sync, active-high), stalled (PC held this cycle),
//        timeout (sticky until reset).
module stall_watchdog #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stalled,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  logic [7:0] r_cnt;
  logic       r_timeout;
  logic [7:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else if (stalled) begin
      if (r_cnt != 8'hFF) begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc == LIMIT) r_timeout <= 1'b1;
      end
    end else begin
      r_cnt <= 8'd0;
    end
  end

  assign timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / exception controller.
// Inputs : clk, rst (sync, active-high), stallreq_from_{if,id,ex,mem},
//          excepttype_i (0 none, 0xe ERET), cp0_epc_i.
// Outputs: stall[5:0] per-stage hold, flush, new_pc (redirect target),
//          stall_timeout (sticky), stall_cycles (total PC-stalled cycles).
// stall/flush/new_pc are combinational; counters are registered.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 255,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nxt;
  logic [5:0]  w_stall;
  logic        w_flush;
  logic [31:0] w_new_pc;
  logic [31:0] r_stall_cycles;

  always_comb begin
    w_stall     = 6'b0;
    w_flush     = 1'b0;
    w_new_pc    = 32'h0;
    w_state_nxt = ST_RUN;
    if (!rst) begin
      if (excepttype_i == EXC_ERET)       w_new_pc = cp0_epc_i;
      else if (excepttype_i != EXC_NONE)  w_new_pc = EXC_VECTOR;
      case (r_state)
        ST_RUN: begin
          if (excepttype_i != EXC_NONE) begin
            // Exception outranks any stall: flushed stages must not hold.
            w_flush     = 1'b1;
            w_state_nxt = ST_RECOVER;
          end else begin
            w_stall = stall_mask(stallreq_from_if, stallreq_from_id,
                                 stallreq_from_ex, stallreq_from_mem);
          end
        end
        // One dead cycle after a flush; MEM may still show the stale
        // exception code, so nothing is acted on here.
        ST_RECOVER: w_state_nxt = ST_RUN;
        default:    w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_stall_cycles <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall[0]) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  stall_watchdog #(.STALL_LIMIT(STALL_LIMIT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .stalled (w_stall[0]),
    .timeout (stall_timeout)
  );

  assign stall        = w_stall;
  assign flush        = w_flush;
  assign new_pc       = w_new_pc;
  assign stall_cycles = r_stall_cycles;

endmodule
